// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Depth, widths, lock state and the per-requester request bundle.
package dmem_pkg;

    localparam int DEPTH    = 8;
    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int LOCK_MAX = 4;
    localparam int CW       = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        OPEN,
        LOCKED
    } lock_state_e;

    typedef struct packed {
        logic          req;
        logic          we;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dmem_req_t;

    function automatic logic in_range(input logic [AW-1:0] a);
        return a < AW'(DEPTH);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
// The requester uses master; the arbiter uses slave.
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/dmem_arb_resp.sv
// Per-requester response register: one rvalid pulse per grant.
// rdata is zero for writes and out-of-range accesses and holds otherwise.
module dmem_arb_resp
    import dmem_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          gnt,
    input  logic          we,
    input  logic          oor,
    input  logic [DW-1:0] mem_dout,
    output logic          rvalid,
    output logic [DW-1:0] rdata,
    output logic          err
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            rvalid <= gnt;
            if (gnt) begin
                rdata <= (we || oor) ? '0 : mem_dout;
                err   <= oor;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter with bounded lock in front of the 8x8 data memory.
// DMEM_ARB_RR_EN selects round-robin contention; default is m0 priority.
module dmem_arbiter
    import dmem_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  m0,
    dmem_arbiter_if.slave  m1,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_di,
    input  logic [DW-1:0]  mem_dout
);

    dmem_req_t   r0, r1;
    lock_state_e state_q, state_d;
    logic        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic        yield_q, yield_d;
    logic        g0, g1, pri1, hold, win_lock;
    logic        in0, in1;

    assign r0 = {m0.req, m0.we, m0.lock, m0.addr, m0.wdata};
    assign r1 = {m1.req, m1.we, m1.lock, m1.addr, m1.wdata};
    assign in0 = in_range(r0.addr);
    assign in1 = in_range(r1.addr);
    assign cnt_inc = cnt_q + CW'(1);

`ifdef DMEM_ARB_RR_EN
    logic last_q, last_d;

    always_ff @(posedge clk) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if (g0)      last_d = 1'b0;
        else if (g1) last_d = 1'b1;
    end

    assign pri1 = yield_q ? !owner_q : !last_q;
`else
    assign pri1 = yield_q & !owner_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OPEN;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            yield_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            yield_q <= yield_d;
        end
    end

    always_comb begin
        g0       = 1'b0;
        g1       = 1'b0;
        state_d  = OPEN;
        owner_d  = owner_q;
        cnt_d    = '0;
        yield_d  = 1'b0;
        hold     = (state_q == LOCKED) && (owner_q ? r1.req : r0.req);
        if (hold) begin
            g0 = !owner_q;
            g1 = owner_q;
        end else if (r0.req && r1.req) begin
            g0 = !pri1;
            g1 = pri1;
        end else begin
            g0 = r0.req;
            g1 = r1.req;
        end
        if (!rst_n) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end
        win_lock = g1 ? r1.lock : (g0 & r0.lock);
        // Reaching LOCK_MAX ends the lock and hands the next contention away
        if (win_lock) begin
            if (hold) begin
                if (cnt_inc >= CW'(LOCK_MAX)) begin
                    yield_d = 1'b1;
                end else begin
                    state_d = LOCKED;
                    cnt_d   = cnt_inc;
                end
            end else begin
                state_d = LOCKED;
                owner_d = g1;
                cnt_d   = CW'(1);
            end
        end
    end

    assign m0.gnt   = g0;
    assign m1.gnt   = g1;
    assign mem_we   = (g0 & r0.we & in0) | (g1 & r1.we & in1);
    assign mem_addr = g0 ? r0.addr  : (g1 ? r1.addr  : '0);
    assign mem_di   = g0 ? r0.wdata : (g1 ? r1.wdata : '0);

    dmem_arb_resp u_resp0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .gnt      (g0),
        .we       (r0.we),
        .oor      (!in0),
        .mem_dout (mem_dout),
        .rvalid   (m0.rvalid),
        .rdata    (m0.rdata),
        .err      (m0.err)
    );

    dmem_arb_resp u_resp1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .gnt      (g1),
        .we       (r1.we),
        .oor      (!in1),
        .mem_dout (mem_dout),
        .rvalid   (m1.rvalid),
        .rdata    (m1.rdata),
        .err      (m1.err)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table with a response scoreboard,
// plus a hand-written bounded-lock sequence.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_we;
    logic [7:0] mem_addr, mem_di, mem_dout;
    logic [7:0] mem [8];

    dmem_arbiter_if m0_if ();
    dmem_arbiter_if m1_if ();

    dmem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0       (m0_if),
        .m1       (m1_if),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_di   (mem_di),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    always @(posedge clk) if (mem_we) mem[mem_addr[2:0]] <= mem_di;
    assign mem_dout = (mem_addr < 8) ? mem[mem_addr[2:0]] : 8'h00;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit       rst;
        bit       r0, w0, l0;
        bit [7:0] a0, d0;
        bit       r1, w1, l1;
        bit [7:0] a1, d1;
        bit       g0, g1;
    } vec_t;

    typedef struct {
        bit       id;
        bit [7:0] rd;
        bit       err;
    } exp_t;

    exp_t     sbq[$];
    bit [7:0] ref_mem [8];
    bit [7:0] hold0, hold1;
    int       n_cmp = 0;
    int       n_bad = 0;
    vec_t     tbl [29];

    function automatic vec_t v(
        input bit rst,
        input bit r0, input bit w0, input bit l0,
        input bit [7:0] a0, input bit [7:0] d0,
        input bit r1, input bit w1, input bit l1,
        input bit [7:0] a1, input bit [7:0] d1,
        input bit g0, input bit g1);
        vec_t t;
        t.rst = rst;
        t.r0 = r0; t.w0 = w0; t.l0 = l0; t.a0 = a0; t.d0 = d0;
        t.r1 = r1; t.w1 = w1; t.l1 = l1; t.a1 = a1; t.d1 = d1;
        t.g0 = g0; t.g1 = g1;
        return t;
    endfunction

    task automatic chk(input string nm, input int row,
                       input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input bit id, input bit we,
                                    input bit [7:0] a);
        exp_t e;
        e.id  = id;
        e.err = (a >= 8);
        e.rd  = (we || a >= 8) ? 8'h00 : ref_mem[a[2:0]];
        return e;
    endfunction

    task automatic run(input vec_t t, input int k);
        exp_t e;
        bit   ev0, ev1, ee0, ee1, xwe;
        bit [7:0] xaddr;
        rst_n = t.rst;
        m0_if.req = t.r0; m0_if.we = t.w0; m0_if.lock = t.l0;
        m0_if.addr = t.a0; m0_if.wdata = t.d0;
        m1_if.req = t.r1; m1_if.we = t.w1; m1_if.lock = t.l1;
        m1_if.addr = t.a1; m1_if.wdata = t.d1;
        #4;
        xwe = (t.g0 && t.w0 && t.a0 < 8) || (t.g1 && t.w1 && t.a1 < 8);
        xaddr = t.g0 ? t.a0 : (t.g1 ? t.a1 : 8'h00);
        chk("m0_gnt", k, 8'(m0_if.gnt), 8'(t.g0));
        chk("m1_gnt", k, 8'(m1_if.gnt), 8'(t.g1));
        chk("mem_we", k, 8'(mem_we), 8'(xwe));
        chk("mem_addr", k, mem_addr, xaddr);
        if (t.g0) begin
            sbq.push_back(mk_exp(1'b0, t.w0, t.a0));
            if (t.w0 && t.a0 < 8) ref_mem[t.a0[2:0]] = t.d0;
        end
        if (t.g1) begin
            sbq.push_back(mk_exp(1'b1, t.w1, t.a1));
            if (t.w1 && t.a1 < 8) ref_mem[t.a1[2:0]] = t.d1;
        end
        @(posedge clk);
        #1;
        if (!t.rst) begin
            sbq.delete();
            hold0 = 8'h00;
            hold1 = 8'h00;
        end
        ev0 = 0; ev1 = 0; ee0 = 0; ee1 = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.id) begin ev1 = 1; hold1 = e.rd; ee1 = e.err; end
            else      begin ev0 = 1; hold0 = e.rd; ee0 = e.err; end
        end
        chk("m0_rvalid", k, 8'(m0_if.rvalid), 8'(ev0));
        chk("m1_rvalid", k, 8'(m1_if.rvalid), 8'(ev1));
        chk("m0_rdata", k, m0_if.rdata, hold0);
        chk("m1_rdata", k, m1_if.rdata, hold1);
        if (ev0) chk("m0_err", k, 8'(m0_if.err), 8'(ee0));
        if (ev1) chk("m1_err", k, 8'(m1_if.err), 8'(ee1));
    endtask

    initial begin
        int  n0;
        bit  seen;
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
        hold0 = 8'h00;
        hold1 = 8'h00;
        rst_n = 1'b0;
        m0_if.req = 0; m0_if.we = 0; m0_if.lock = 0;
        m0_if.addr = 0; m0_if.wdata = 0;
        m1_if.req = 0; m1_if.we = 0; m1_if.lock = 0;
        m1_if.addr = 0; m1_if.wdata = 0;

        tbl[0]  = v(0, 0,0,0,8'd0,8'h00, 0,0,0,8'd0,8'h00, 0,0);
        tbl[1]  = v(1, 1,1,0,8'd3,8'hA5, 0,0,0,8'd0,8'h00, 1,0);
        tbl[2]  = v(1, 1,0,0,8'd3,8'h00, 0,0,0,8'd0,8'h00, 1,0);
        tbl[3]  = v(1, 0,0,0,8'd0,8'h00, 1,0,0,8'd0,8'h00, 0,1);
        for (int i = 0; i < 4; i++)
            tbl[4+i] = v(1, 1,0,0,8'd3,8'h00, 1,0,0,8'd2,8'h00,
                         !(RR && i[0]), RR && i[0]);
        tbl[8]  = v(1, 0,0,0,8'd0,8'h00, 1,0,1,8'd5,8'h00, 0,1);
        tbl[9]  = v(1, 1,0,0,8'd3,8'h00, 1,1,0,8'd5,8'h3C, 0,1);
        tbl[10] = v(1, 1,0,0,8'd3,8'h00, 0,0,0,8'd0,8'h00, 1,0);
        tbl[11] = v(1, 0,0,0,8'd0,8'h00, 1,0,0,8'd5,8'h00, 0,1);
        for (int i = 0; i < 5; i++)
            tbl[12+i] = v(1, 1,0,1,8'd5,8'h00, 1,0,0,8'd3,8'h00,
                          i != 4, i == 4);
        tbl[17] = v(1, 1,0,1,8'd5,8'h00, 0,0,0,8'd0,8'h00, 1,0);
        tbl[18] = v(1, 1,0,0,8'd5,8'h00, 0,0,0,8'd0,8'h00, 1,0);
        tbl[19] = v(1, 0,0,0,8'd0,8'h00, 1,1,0,8'd9,8'h77, 0,1);
        tbl[20] = v(1, 1,0,0,8'd1,8'h00, 0,0,0,8'd0,8'h00, 1,0);
        tbl[21] = v(1, 1,0,0,8'hC8,8'h00, 0,0,0,8'd0,8'h00, 1,0);
        tbl[22] = v(1, 1,0,1,8'd2,8'h00, 0,0,0,8'd0,8'h00, 1,0);
        tbl[23] = v(0, 1,1,1,8'd2,8'hEE, 1,0,0,8'd2,8'h00, 0,0);
        tbl[24] = v(1, 0,0,0,8'd0,8'h00, 1,0,0,8'd2,8'h00, 0,1);
        tbl[25] = v(1, 0,0,0,8'd0,8'h00, 0,0,0,8'd0,8'h00, 0,0);
        tbl[26] = v(1, 1,0,1,8'd4,8'h00, 0,0,0,8'd0,8'h00, 1,0);
        tbl[27] = v(1, 0,0,0,8'd0,8'h00, 1,0,0,8'd4,8'h00, 0,1);
        tbl[28] = v(1, 0,0,0,8'd0,8'h00, 0,0,0,8'd0,8'h00, 0,0);

        @(posedge clk);
        #1;
        for (int k = 0; k < 29; k++) run(tbl[k], k);

        // m0 holds lock while m1 waits: m1 must get in after LOCK_MAX grants
        m0_if.req = 1; m0_if.we = 0; m0_if.lock = 1; m0_if.addr = 8'd6;
        m1_if.req = 1; m1_if.we = 0; m1_if.lock = 0; m1_if.addr = 8'd6;
        n0 = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #4;
            if (m1_if.gnt) seen = 1;
            else if (m0_if.gnt) n0++;
            @(posedge clk);
            #1;
        end
        chk("m1_gnt_seen", 100, 8'(seen), 8'd1);
        chk("m0_lock_grants", 100, 8'(n0), 8'd4);
        m0_if.req = 0;
        m1_if.req = 0;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port 8x8 data memory: it shares the memory between requester 0 (core load/store path) and requester 1 (loader/debug port). It performs one access per cycle, range-checks addresses against the memory depth, and returns registered read data. It supports short locked sequences, for example atomic read-modify-write, with a bounded hold time.

## Interface
- DEPTH, 8, number of memory words; addresses >= DEPTH are out of range
- AW, 8, address width
- DW, 8, data width
- LOCK_MAX, 4, max consecutive locked grants to one requester (>= 2)

- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- mN_req  in  1  requester N (N = 0, 1) wants an access this cycle
- mN_we  in  1  1 = write, 0 = read
- mN_lock  in  1  keep grant next cycle (valid with mN_req)
- mN_addr  in  AW  word address
- mN_wdata  in  DW  write data
- mN_gnt  out  1  access accepted this cycle (combinational)
- mN_rvalid  out  1  response valid (registered)
- mN_rdata  out  DW  read data (registered)
- mN_err  out  1  granted access was out of range (registered, with rvalid)
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_di  out  DW  memory write data
- mem_dout  in  DW  memory combinational read data

## Operation
- Grant: at most one of m0_gnt/m1_gnt per cycle; gnt implies req. Grant is forced to 0 while rst_n = 0.
- Memory drive: mem_addr and mem_di come from the granted requester, else 0. mem_we = gnt & we & (addr < DEPTH) & rst_n.
- Arbitration in state OPEN:
  - Only one requester asserts req: that requester is granted.
  - Both assert req: the requester not in register `last` wins.
  - `last` updates to the winner on every grant.
- Lock FSM: states OPEN, LOCKED.
  - OPEN -> LOCKED when the granted requester has lock = 1. owner = winner, lock_cnt = 1.
  - In LOCKED, the owner is granted if it requests. The other requester is stalled while the owner requests.
  - Each locked grant with lock = 1 increments lock_cnt.
  - LOCKED -> OPEN when any of these holds:
    - the owner deasserts req;
    - the owner is granted with lock = 0;
    - lock_cnt reaches LOCK_MAX; that grant proceeds, then the other requester gets priority in the next cycle.
  - If the owner drops req while locked, the other requester may be granted in that same cycle.
- Response:
  - For each grant, mN_rvalid pulses for exactly 1 cycle in the next cycle, for both reads and writes.
  - mN_rdata = mem_dout captured at the grant edge for in-range reads, else 0.
  - mN_err = 1 iff addr >= DEPTH.
  - Out-of-range write: no memory write occurs.
- rdata holds its value between responses. It is not cleared when rvalid falls.

## Timing
- Reset values: gnt 0, rvalid 0, rdata 0, err 0, mem_we 0, mem_addr 0, mem_di 0. State = OPEN, `last` = 1 (m0 wins first contention), lock_cnt = 0.
- Latency: write commits at the grant edge. Read response 1 cycle after grant. Throughput: 1 access/cycle.
- Handshake: a requester holds req/we/addr/wdata stable until it sees gnt, then may change them next cycle. req may drop without a grant.
- Back-to-back grants to the same requester produce back-to-back rvalid pulses.
- Reset asserted mid-lock: returns to OPEN next edge. No write occurs in any cycle with rst_n = 0. A pending response from the previous cycle is dropped.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin contention via `last`, as described above.
- DMEM_ARB_RR_EN undefined: fixed priority, m0 always wins contention in OPEN. `last` is not implemented.
- Lock rules and LOCK_MAX release apply in both builds. In the fixed-priority build, the LOCK_MAX forced release still grants m1 one cycle.

## Structure
- Shared package dmem_pkg:
  - DEPTH, AW and DW constants;
  - lock state enum typedef (OPEN, LOCKED);
  - request struct typedef (req, we, lock, addr, wdata).
- Sub-module dmem_arb_resp: per-requester response register (rvalid/rdata/err). It is instantiated twice. The arbiter FSM stays in the top module.

## Test plan
- Reset, then m0 writes 0xA5 to addr 3 and reads addr 3 -> read rvalid pulses in the cycle after its grant, with m0_rdata = 0xA5 and err = 0.
- m0 and m1 both request reads every cycle for 4 cycles (RR build) -> grants go m0, m1, m0, m1.
- RR build undefined, same stimulus -> m0 granted all 4 cycles, m1_gnt stays 0.
- m1 reads addr 5 with lock = 1, then writes addr 5 with lock = 0, while m0 requests continuously -> m1 granted 2 consecutive cycles, then m0 is granted.
- m0 requests with lock held for 6 cycles, m1 requesting (LOCK_MAX = 4) -> m0 granted 4 cycles, m1 granted on the 5th cycle.
- m1 writes 0x77 to addr 9 -> mem_we stays 0, m1_err = 1 next cycle. A subsequent read of addr 1 (previously 0x00) returns 0x00. Drop rst_n during a locked sequence -> all outputs 0 next cycle and no write occurs.
